// File: rtl/alu_shift_exec.sv
// Execute stage of the multi-cycle ARM-subset CPU.
// A barrel shifter builds operand B, a 16-op data-processing ALU combines it
// with operand A, and the result and flags land in the F and NZCV registers.
// The shifter/ALU carry and overflow inputs come from the registered NZCV.
module alu_shift_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] shift_data,
  input  logic [7:0]  shift_num,
  input  logic [2:0]  shift_op,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b_ext,
  input  logic        alu_b_sel,
  input  logic [3:0]  alu_op,
  input  logic        s_en,
  input  logic        load_f,
  output logic [31:0] shift_out,
  output logic        shift_carry_out,
  output logic [31:0] f_comb,
  output logic [31:0] F,
  output logic [3:0]  NZCV
);

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  logic [31:0] f_q, f_d;
  logic [3:0]  nzcv_q, nzcv_d;
  logic        cin, vin;

  assign cin = nzcv_q[1];
  assign vin = nzcv_q[0];

  // Immediate mode only sees the low five bits of the amount.
  logic [7:0] amt;
  assign amt = shift_op[0] ? shift_num : {3'b000, shift_num[4:0]};

  // Wide shift results: the extra bit catches the last bit shifted out.
  logic [32:0]        lsl_w, lsr_w;
  logic signed [32:0] asr_w;
  logic [5:0]         asr_amt;
  logic [63:0]        ror_w;

  assign lsl_w   = {1'b0, shift_data} << amt;
  assign lsr_w   = {shift_data, 1'b0} >> amt;
  assign asr_amt = (amt > 8'd32) ? 6'd32 : amt[5:0];
  assign asr_w   = $signed({shift_data, 1'b0}) >>> asr_amt;
  assign ror_w   = {shift_data, shift_data} >> amt[4:0];

  // Barrel shifter including the ARM amount-zero and >=32 special cases.
  always_comb begin
    shift_out       = shift_data;
    shift_carry_out = cin;
    if (amt == 8'd0) begin
      // Register mode #0 is a pass-through; immediate #0 re-encodes LSR/ASR/ROR.
      if (!shift_op[0]) begin
        case (shift_op[2:1])
          SH_LSR: begin
            shift_out       = 32'd0;
            shift_carry_out = shift_data[31];
          end
          SH_ASR: begin
            shift_out       = {32{shift_data[31]}};
            shift_carry_out = shift_data[31];
          end
          SH_ROR: begin
            shift_out       = {cin, shift_data[31:1]};
            shift_carry_out = shift_data[0];
          end
          default: ;
        endcase
      end
    end else begin
      case (shift_op[2:1])
        SH_LSL: begin
          if (amt <= 8'd32) begin
            shift_out       = lsl_w[31:0];
            shift_carry_out = lsl_w[32];
          end else begin
            shift_out       = 32'd0;
            shift_carry_out = 1'b0;
          end
        end
        SH_LSR: begin
          if (amt <= 8'd32) begin
            shift_out       = lsr_w[32:1];
            shift_carry_out = lsr_w[0];
          end else begin
            shift_out       = 32'd0;
            shift_carry_out = 1'b0;
          end
        end
        SH_ASR: begin
          shift_out       = asr_w[32:1];
          shift_carry_out = asr_w[0];
        end
        default: begin
          // ROR by a multiple of 32 leaves data alone but still reports bit 31.
          if (amt[4:0] == 5'd0) begin
            shift_out       = shift_data;
            shift_carry_out = shift_data[31];
          end else begin
            shift_out       = ror_w[31:0];
            shift_carry_out = ror_w[31];
          end
        end
      endcase
    end
  end

  logic [31:0] b_op;
  assign b_op = alu_b_sel ? alu_b_ext : shift_out;

  logic [31:0] add_x, add_y;
  logic        add_c, arith;
  logic [32:0] sum;
  logic        c_flag, v_flag;
  logic [3:0]  alu_nzcv;

  // ALU: every subtract is folded into X + ~Y + carry so C is NOT borrow.
  always_comb begin
    add_x = alu_a;
    add_y = b_op;
    add_c = 1'b0;
    arith = 1'b1;
    case (alu_op)
      4'h2, 4'hA: begin add_x = alu_a; add_y = ~b_op;  add_c = 1'b1; end
      4'h3:       begin add_x = b_op;  add_y = ~alu_a; add_c = 1'b1; end
      4'h4, 4'hB: begin add_x = alu_a; add_y = b_op;   add_c = 1'b0; end
      4'h5:       begin add_x = alu_a; add_y = b_op;   add_c = cin;  end
      4'h6:       begin add_x = alu_a; add_y = ~b_op;  add_c = cin;  end
      4'h7:       begin add_x = b_op;  add_y = ~alu_a; add_c = cin;  end
      default:    arith = 1'b0;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_c};
    case (alu_op)
      4'h0, 4'h8: f_comb = alu_a & b_op;
      4'h1, 4'h9: f_comb = alu_a ^ b_op;
      4'hC:       f_comb = alu_a | b_op;
      4'hD:       f_comb = b_op;
      4'hE:       f_comb = alu_a & ~b_op;
      4'hF:       f_comb = ~b_op;
      default:    f_comb = sum[31:0];
    endcase
    c_flag   = arith ? sum[32] : shift_carry_out;
    v_flag   = arith ? ((add_x[31] == add_y[31]) && (sum[31] != add_x[31])) : vin;
    alu_nzcv = {f_comb[31], (f_comb == 32'd0), c_flag, v_flag};
  end

  // Independent load enables for the result and flag registers.
  always_comb begin
    f_d    = load_f ? f_comb : f_q;
    nzcv_d = s_en ? alu_nzcv : nzcv_q;
  end

  // Result and flag registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= 32'd0;
      nzcv_q <= 4'd0;
    end else begin
      f_q    <= f_d;
      nzcv_q <= nzcv_d;
    end
  end

  assign F    = f_q;
  assign NZCV = nzcv_q;

endmodule

// File: tb/tb_alu_shift_exec.sv
// Bench for alu_shift_exec: directed shifter table, directed ALU/flag
// sequences, reset sequence, and random stimulus against a reference model.
module tb_alu_shift_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] shift_data;
  logic [7:0]  shift_num;
  logic [2:0]  shift_op;
  logic [31:0] alu_a, alu_b_ext;
  logic        alu_b_sel;
  logic [3:0]  alu_op;
  logic        s_en, load_f;
  logic [31:0] shift_out, f_comb, F;
  logic        shift_carry_out;
  logic [3:0]  NZCV;

  always #5 clk = ~clk;

  alu_shift_exec dut (
    .clk(clk), .rst(rst),
    .shift_data(shift_data), .shift_num(shift_num), .shift_op(shift_op),
    .alu_a(alu_a), .alu_b_ext(alu_b_ext), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .s_en(s_en), .load_f(load_f),
    .shift_out(shift_out), .shift_carry_out(shift_carry_out),
    .f_comb(f_comb), .F(F), .NZCV(NZCV)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model register state.
  logic [31:0] m_f;
  logic [3:0]  m_nzcv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Shifter reference written directly from the ARM shift rules.
  function automatic void ref_shift(input logic [31:0] d, input logic [2:0] op,
                                    input logic [7:0] num, input logic ci,
                                    output logic [31:0] o, output logic c);
    int n, m;
    n = op[0] ? int'(num) : int'(num[4:0]);
    o = d; c = ci;
    if (n == 0 && op[0]) return;
    if (n == 0) begin
      case (op[2:1])
        2'd0: return;
        2'd1, 2'd2: n = 32;
        default: begin o = {ci, d[31:1]}; c = d[0]; return; end
      endcase
    end
    case (op[2:1])
      2'd0: begin
        if (n < 32) begin o = d << n; c = d[32-n]; end
        else if (n == 32) begin o = 0; c = d[0]; end
        else begin o = 0; c = 0; end
      end
      2'd1: begin
        if (n < 32) begin o = d >> n; c = d[n-1]; end
        else if (n == 32) begin o = 0; c = d[31]; end
        else begin o = 0; c = 0; end
      end
      2'd2: begin
        if (n >= 32) begin o = {32{d[31]}}; c = d[31]; end
        else begin o = 32'($signed(d) >>> n); c = d[n-1]; end
      end
      default: begin
        m = n % 32;
        if (m == 0) begin o = d; c = d[31]; end
        else begin o = (d >> m) | (d << (32 - m)); c = o[31]; end
      end
    endcase
  endfunction

  // ALU reference using plain 64-bit integer arithmetic.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, b,
                                  input logic ci, vi, shc,
                                  output logic [31:0] f, output logic [3:0] fl);
    longint ua, ub, sa, sb, u, s, k;
    logic c, v, arith, sub;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    k = ci ? 64'sd1 : 64'sd0;
    arith = 1; sub = 1; u = 0; s = 0; f = 0;
    case (op)
      4'h2, 4'hA: begin u = ua - ub; s = sa - sb; end
      4'h3:       begin u = ub - ua; s = sb - sa; end
      4'h4, 4'hB: begin u = ua + ub; s = sa + sb; sub = 0; end
      4'h5:       begin u = ua + ub + k; s = sa + sb + k; sub = 0; end
      4'h6:       begin u = ua - ub + k - 1; s = sa - sb + k - 1; end
      4'h7:       begin u = ub - ua + k - 1; s = sb - sa + k - 1; end
      4'h0, 4'h8: begin arith = 0; f = a & b; end
      4'h1, 4'h9: begin arith = 0; f = a ^ b; end
      4'hC:       begin arith = 0; f = a | b; end
      4'hD:       begin arith = 0; f = b; end
      4'hE:       begin arith = 0; f = a & ~b; end
      default:    begin arith = 0; f = ~b; end
    endcase
    if (arith) begin
      f = u[31:0];
      c = sub ? (u >= 0) : (u >= 64'sh1_0000_0000);
      v = (s != longint'($signed(s[31:0])));
    end else begin
      c = shc; v = vi;
    end
    fl = {f[31], (f == 32'd0), c, v};
  endfunction

  // One clock edge; model registers follow the inputs presented before it.
  task automatic step();
    logic [31:0] so, fo;
    logic sc;
    logic [3:0] fl;
    ref_shift(shift_data, shift_op, shift_num, m_nzcv[1], so, sc);
    ref_alu(alu_op, alu_a, alu_b_sel ? alu_b_ext : so, m_nzcv[1], m_nzcv[0], sc, fo, fl);
    @(posedge clk);
    if (rst) begin
      m_f = 0; m_nzcv = 0;
    end else begin
      if (load_f) m_f = fo;
      if (s_en) m_nzcv = fl;
    end
    #1;
  endtask

  // Set C through a CMP on the extended operand (5-5 -> C=1, 5-6 -> C=0).
  task automatic set_cin(input logic c);
    alu_b_sel = 1; alu_a = 32'd5; alu_b_ext = c ? 32'd5 : 32'd6;
    alu_op = 4'hA; s_en = 1; load_f = 0;
    step();
    s_en = 0;
  endtask

  typedef struct {
    string       name;
    logic        cin;
    logic [2:0]  op;
    logic [7:0]  num;
    logic [31:0] data;
    logic [31:0] exp_out;
    logic        exp_c;
  } sh_vec_t;

  sh_vec_t vecs[$];

  initial begin
    vecs.push_back('{"ror_imm0",   1'b1, 3'b110, 8'd0,   32'h80000001, 32'hC0000000, 1'b1});
    vecs.push_back('{"lsr_imm0",   1'b1, 3'b010, 8'd0,   32'h80000001, 32'h00000000, 1'b1});
    vecs.push_back('{"asr_imm4",   1'b1, 3'b100, 8'd4,   32'h80000001, 32'hF8000000, 1'b0});
    vecs.push_back('{"asr_imm0",   1'b0, 3'b100, 8'd0,   32'h80000001, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"lsl_imm0",   1'b0, 3'b000, 8'd0,   32'h80000001, 32'h80000001, 1'b0});
    vecs.push_back('{"lsl_imm1",   1'b0, 3'b000, 8'd1,   32'h80000001, 32'h00000002, 1'b1});
    vecs.push_back('{"lsl_imm_w",  1'b0, 3'b000, 8'h21,  32'h80000001, 32'h00000002, 1'b1});
    vecs.push_back('{"ror_imm4",   1'b0, 3'b110, 8'd4,   32'h80000001, 32'h18000000, 1'b0});
    vecs.push_back('{"lsl_reg32",  1'b0, 3'b001, 8'd32,  32'h80000001, 32'h00000000, 1'b1});
    vecs.push_back('{"lsl_reg33",  1'b1, 3'b001, 8'd33,  32'h80000001, 32'h00000000, 1'b0});
    vecs.push_back('{"lsr_reg32",  1'b0, 3'b011, 8'd32,  32'h80000001, 32'h00000000, 1'b1});
    vecs.push_back('{"lsr_reg40",  1'b1, 3'b011, 8'd40,  32'h80000001, 32'h00000000, 1'b0});
    vecs.push_back('{"asr_reg200", 1'b0, 3'b101, 8'd200, 32'h80000001, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"ror_reg32",  1'b0, 3'b111, 8'd32,  32'h80000001, 32'h80000001, 1'b1});
    vecs.push_back('{"ror_reg36",  1'b0, 3'b111, 8'd36,  32'h80000001, 32'h18000000, 1'b0});
    vecs.push_back('{"reg0_c1",    1'b1, 3'b011, 8'd0,   32'h80000001, 32'h80000001, 1'b1});
    vecs.push_back('{"reg0_c0",    1'b0, 3'b111, 8'd0,   32'h80000001, 32'h80000001, 1'b0});
  end

  initial begin
    rst = 1; shift_data = 0; shift_num = 0; shift_op = 0;
    alu_a = 0; alu_b_ext = 0; alu_b_sel = 0; alu_op = 0; s_en = 0; load_f = 0;
    m_f = 0; m_nzcv = 0;
    #2;
    chk("reset_F", F, 32'd0);
    chk("reset_NZCV", {28'd0, NZCV}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    // ADD overflow: B = data 1 through LSL #0.
    shift_data = 32'd1; shift_op = 3'b000; shift_num = 8'd0; alu_b_sel = 0;
    alu_a = 32'h7FFFFFFF; alu_op = 4'h4; s_en = 1; load_f = 1;
    step();
    chk("add_ovf_F", F, 32'h80000000);
    chk("add_ovf_NZCV", {28'd0, NZCV}, 32'h9);

    // SUB equal.
    alu_b_sel = 1; alu_a = 32'd5; alu_b_ext = 32'd5; alu_op = 4'h2;
    step();
    chk("sub_eq_F", F, 32'd0);
    chk("sub_eq_NZCV", {28'd0, NZCV}, 32'h6);

    // CMP 3 vs 5 with the result write suppressed.
    alu_a = 32'd3; alu_b_ext = 32'd5; alu_op = 4'hA; load_f = 0;
    #1 chk("cmp_fcomb", f_comb, 32'hFFFFFFFE);
    step();
    chk("cmp_F_held", F, 32'd0);
    chk("cmp_NZCV", {28'd0, NZCV}, 32'h8);

    // Shifter table.
    foreach (vecs[i]) begin
      set_cin(vecs[i].cin);
      shift_data = vecs[i].data; shift_op = vecs[i].op; shift_num = vecs[i].num;
      #1;
      chk({vecs[i].name, "_out"}, shift_out, vecs[i].exp_out);
      chk({vecs[i].name, "_c"}, {31'd0, shift_carry_out}, {31'd0, vecs[i].exp_c});
    end

    // Logical op keeps V and takes C from the shifter.
    alu_b_sel = 1; alu_a = 32'h80000000; alu_b_ext = 32'h80000000; alu_op = 4'h4;
    s_en = 1; load_f = 0;
    step();
    chk("prep_NZCV", {28'd0, NZCV}, 32'h7);
    alu_b_sel = 0; shift_data = 32'h80000001; shift_op = 3'b110; shift_num = 0;
    alu_a = 32'hFFFFFFFF; alu_op = 4'h0; load_f = 1;
    step();
    chk("and_F", F, 32'hC0000000);
    chk("and_NZCV", {28'd0, NZCV}, 32'hB);

    // ADC with Cin=1 and zero operands.
    set_cin(1'b1);
    alu_b_sel = 1; alu_a = 0; alu_b_ext = 0; alu_op = 4'h5; s_en = 1; load_f = 1;
    step();
    chk("adc_F", F, 32'd1);
    chk("adc_NZCV", {28'd0, NZCV}, 32'h0);

    // Extended B operand.
    alu_a = 32'h100; alu_b_ext = 32'hFFFFFFF8; alu_op = 4'h4;
    step();
    chk("bext_F", F, 32'hF8);
    chk("bext_NZCV", {28'd0, NZCV}, 32'h2);

    // Independent enables: flags only, F held.
    alu_a = 32'd1; alu_b_ext = 32'd2; alu_op = 4'h2; load_f = 0; s_en = 1;
    step();
    chk("sonly_F", F, 32'hF8);
    chk("sonly_NZCV", {28'd0, NZCV}, 32'h8);

    // Reset in the middle of operation.
    alu_a = 32'h12345678; alu_b_ext = 32'd1; alu_op = 4'h4; load_f = 1; s_en = 1;
    step();
    chk("pre_rst_F", F, 32'h12345679);
    alu_a = 32'hFFFFFFFF; alu_b_ext = 32'hFFFFFFFF;
    #2 rst = 1;
    #1;
    chk("rst_async_F", F, 32'd0);
    chk("rst_async_NZCV", {28'd0, NZCV}, 32'd0);
    step();
    chk("rst_hold_F", F, 32'd0);
    chk("rst_hold_NZCV", {28'd0, NZCV}, 32'd0);
    rst = 0;
    alu_a = 32'h10; alu_b_ext = 32'h20;
    step();
    chk("post_rst_F", F, 32'h30);
    chk("post_rst_NZCV", {28'd0, NZCV}, 32'h0);

    // Random stimulus against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] so, fo;
      logic sc;
      logic [3:0] fl;
      shift_data = ($urandom_range(0, 4) == 0) ? 32'h80000001 : $urandom;
      shift_num  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      shift_op   = 3'($urandom);
      alu_a      = $urandom;
      alu_b_ext  = $urandom;
      alu_b_sel  = 1'($urandom);
      alu_op     = 4'($urandom);
      s_en       = ($urandom_range(0, 3) != 0);
      load_f     = 1'($urandom);
      #1;
      ref_shift(shift_data, shift_op, shift_num, m_nzcv[1], so, sc);
      ref_alu(alu_op, alu_a, alu_b_sel ? alu_b_ext : so, m_nzcv[1], m_nzcv[0], sc, fo, fl);
      chk("rnd_shift_out", shift_out, so);
      chk("rnd_shift_c", {31'd0, shift_carry_out}, {31'd0, sc});
      chk("rnd_f_comb", f_comb, fo);
      step();
      chk("rnd_F", F, m_f);
      chk("rnd_NZCV", {28'd0, NZCV}, {28'd0, m_nzcv});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
